// File: rtl/game_sequencer_if.sv
// Actor handshake bundle: the sequencer strobes step, each actor answers with done.
interface game_sequencer_if;
    logic [4:0] step;
    logic [4:0] done;

    modport master (output step, input done);
    modport slave  (input step, output done);
endinterface

// File: rtl/game_sequencer.sv
// Game-state FSM plus frame-paced step sequencer that strobes pacman and four
// ghosts in turn, with per-actor timeout detection and dropped-tick accounting.
module game_sequencer #(
    parameter logic [9:0] VTICK_LINE = 10'd480,
    parameter int         TIMEOUT    = 64
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    ack,
    input  logic [9:0]              hCount,
    input  logic [9:0]              vCount,
    input  logic [1:0]              speed_sel,
    input  logic                    win_in,
    input  logic                    lose_in,
    game_sequencer_if.master        actor,
    output logic [1:0]              state,
    output logic                    play_en,
    output logic                    clear,
    output logic                    busy,
    output logic [4:0]              timeout_err,
    output logic [7:0]              overrun_cnt
);

    typedef enum logic [1:0] {
        G_INIT = 2'b00,
        G_PLAY = 2'b01,
        G_WIN  = 2'b10,
        G_LOSE = 2'b11
    } game_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } seq_e;

    localparam int            TW     = $clog2(TIMEOUT + 1);
    // Last WAIT cycle: the step gives up after TIMEOUT-1 WAIT cycles.
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT - 2);

    game_e         game_q, game_d;
    seq_e          seq_q, seq_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    fcnt_q, fcnt_d;
    logic [1:0]    div_sel_q, div_sel_d;
    logic          frame_tick_q, frame_tick_d;
    logic          clear_q, clear_d;
    logic [4:0]    terr_q, terr_d;
    logic [7:0]    ovr_q, ovr_d;

    logic [2:0]    div_max;
    logic          move_tick;
    logic [4:0]    step_vec;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        frame_tick_d = (vCount == VTICK_LINE) && (hCount == 10'd0);
        game_d       = game_q;
        clear_d      = 1'b0;
        fcnt_d       = fcnt_q;
        div_sel_d    = div_sel_q;
        move_tick    = 1'b0;
        seq_d        = seq_q;
        idx_d        = idx_q;
        tcnt_d       = tcnt_q;
        terr_d       = terr_q;
        ovr_d        = ovr_q;
        step_vec     = 5'b0;

        unique case (game_q)
            G_INIT: if (start) begin
                game_d  = G_PLAY;
                clear_d = 1'b1;
            end
            G_PLAY: begin
                if (lose_in)     game_d = G_LOSE;
                else if (win_in) game_d = G_WIN;
            end
            G_WIN, G_LOSE: if (ack) game_d = G_INIT;
        endcase

        unique case (div_sel_q)
            2'd0: div_max = 3'd0;
            2'd1: div_max = 3'd1;
            2'd2: div_max = 3'd3;
            2'd3: div_max = 3'd7;
        endcase

        // The divisor is only re-sampled at a wrap so a speed change never truncates a period.
        if (game_q != G_PLAY) begin
            fcnt_d    = 3'd0;
            div_sel_d = speed_sel;
        end else if (frame_tick_q) begin
            if (fcnt_q == div_max) begin
                move_tick = 1'b1;
                fcnt_d    = 3'd0;
                div_sel_d = speed_sel;
            end else begin
                fcnt_d = fcnt_q + 3'd1;
            end
        end

        unique case (seq_q)
            S_IDLE: if (move_tick) begin
                idx_d = 3'd0;
                seq_d = S_ISSUE;
            end
            S_ISSUE: begin
                step_vec[idx_q] = 1'b1;
                tcnt_d          = '0;
                seq_d           = S_WAIT;
            end
            S_WAIT: begin
                if (actor.done[idx_q] || (tcnt_q == TLIMIT)) begin
                    if (!actor.done[idx_q]) terr_d[idx_q] = 1'b1;
                    if (idx_q == 3'd4) begin
                        seq_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        seq_d = S_ISSUE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: seq_d = S_IDLE;
        endcase

        if (move_tick && (seq_q != S_IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

        // Leaving PLAY aborts the burst at the same edge the game state changes.
        if (game_d != G_PLAY) seq_d = S_IDLE;

        if (clear_d) begin
            terr_d = 5'b0;
            ovr_d  = 8'd0;
        end
    end

    // NOTE: Reset is asynchronous and every flop here is reset; there is no memory array to exempt.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            game_q       <= G_INIT;
            seq_q        <= S_IDLE;
            idx_q        <= 3'd0;
            tcnt_q       <= '0;
            fcnt_q       <= 3'd0;
            div_sel_q    <= 2'd0;
            frame_tick_q <= 1'b0;
            clear_q      <= 1'b0;
            terr_q       <= 5'b0;
            ovr_q        <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            game_q       <= game_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            tcnt_q       <= tcnt_d;
            fcnt_q       <= fcnt_d;
            div_sel_q    <= div_sel_d;
            frame_tick_q <= frame_tick_d;
            clear_q      <= clear_d;
            terr_q       <= terr_d;
            ovr_q        <= ovr_d;
        end
    end

    assign actor.step  = step_vec;
    assign state       = game_q;
    assign play_en     = (game_q == G_PLAY);
    assign clear       = clear_q;
    assign busy        = (seq_q != S_IDLE);
    assign timeout_err = terr_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: game FSM, step bursts, timeouts,
// overrun saturation and asynchronous reset.
module tb_game_sequencer;

    logic       board_clk = 1'b0;
    logic       Reset, start, ack, win_in, lose_in;
    logic [9:0] hCount, vCount;
    logic [1:0] speed_sel;
    logic [1:0] state;
    logic       play_en, clear, busy;
    logic [4:0] timeout_err;
    logic [7:0] overrun_cnt;

    game_sequencer_if actor_if ();

    game_sequencer dut (
        .board_clk   (board_clk),
        .Reset       (Reset),
        .start       (start),
        .ack         (ack),
        .hCount      (hCount),
        .vCount      (vCount),
        .speed_sel   (speed_sel),
        .win_in      (win_in),
        .lose_in     (lose_in),
        .actor       (actor_if.master),
        .state       (state),
        .play_en     (play_en),
        .clear       (clear),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_cnt (overrun_cnt)
    );

    always #5 board_clk = ~board_clk;

    int         chk_cnt   = 0;
    int         pass_cnt  = 0;
    int         cyc_cnt   = 0;
    int         multi_hot = 0;
    int         step_log[$];
    int         step_cyc[$];
    logic       auto_done = 1'b0;
    logic [4:0] done_mask = 5'h1F;
    logic [4:0] pend1     = 5'b0;
    logic [4:0] pend2     = 5'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock; records every step strobe with its cycle number.
    task automatic cyc();
        @(posedge board_clk);
        #1;
        cyc_cnt++;
        if (actor_if.step != 5'b0) begin
            if ($countones(actor_if.step) != 1) multi_hot++;
            for (int i = 0; i < 5; i++) begin
                if (actor_if.step[i]) begin
                    step_log.push_back(i);
                    step_cyc.push_back(cyc_cnt);
                end
            end
        end
    endtask

    // Exact tick position, then a near miss on the same line, then idle raster.
    task automatic frame_pulse();
        vCount = 10'd480; hCount = 10'd0; cyc();
        vCount = 10'd480; hCount = 10'd1; cyc();
        vCount = 10'd100; hCount = 10'd5; cyc();
    endtask

    task automatic clear_log();
        step_log.delete();
        step_cyc.delete();
    endtask

    // Actor model: answers done two cycles after its step, filtered by done_mask.
    initial begin
        actor_if.done = 5'b0;
        forever begin
            @(posedge board_clk);
            #1;
            actor_if.done = auto_done ? (pend2 & done_mask) : 5'b0;
            pend2 = pend1;
            pend1 = actor_if.step;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset = 1'b1; start = 1'b0; ack = 1'b0; win_in = 1'b0; lose_in = 1'b0;
        hCount = 10'd5; vCount = 10'd100; speed_sel = 2'd2;
        #1;
        check("reset_outputs", {state, play_en, clear, busy, timeout_err, overrun_cnt, actor_if.step}, 32'd0);
        cyc(); cyc();
        Reset = 1'b0;
        cyc();

        // Frames while in INIT never produce steps.
        clear_log();
        frame_pulse(); frame_pulse();
        check("init_no_steps", step_log.size(), 0);

        // Start: PLAY with a single-cycle clear; a repeated start does nothing.
        start = 1'b1; cyc(); start = 1'b0;
        check("start_state", state, 2'b01);
        check("start_play_en", play_en, 1'b1);
        check("start_clear", clear, 1'b1);
        cyc();
        check("clear_one_cycle", clear, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        check("restart_state", state, 2'b01);
        check("restart_clear", clear, 1'b0);

        // speed_sel=2 with done after 2 cycles: one burst every 4th frame.
        auto_done = 1'b1; done_mask = 5'h1F;
        clear_log();
        for (int f = 0; f < 8; f++) begin
            n = step_log.size();
            frame_pulse();
            repeat (27) cyc();
            check($sformatf("steps_frame%0d", f), step_log.size() - n, (f % 4 == 3) ? 5 : 0);
            check($sformatf("idle_frame%0d", f), busy, 1'b0);
        end
        check("burst_count", step_log.size(), 10);
        if (step_log.size() == 10) begin
            for (int i = 0; i < 10; i++) check($sformatf("burst_order%0d", i), step_log[i], i % 5);
            check("burst_spacing", step_cyc[1] - step_cyc[0], 3);
        end

        // Ghost 3 never answers: flag bit 3, next step 64 cycles later.
        done_mask = 5'b10111;
        clear_log();
        repeat (4) frame_pulse();
        for (int k = 0; k < 600 && !(busy == 1'b0 && step_log.size() >= 5); k++) cyc();
        check("to_idle", busy, 1'b0);
        check("to_steps", step_log.size(), 5);
        if (step_log.size() == 5) begin
            check("to_order3", step_log[3], 3);
            check("to_gap23", step_cyc[3] - step_cyc[2], 3);
            check("to_gap34", step_cyc[4] - step_cyc[3], 64);
        end
        check("to_err", timeout_err, 5'b01000);
        check("to_no_overrun", overrun_cnt, 8'd0);

        // Win, then start and ack together in WIN: only back to INIT.
        win_in = 1'b1; cyc(); win_in = 1'b0;
        check("win_state", state, 2'b10);
        check("win_play_en", play_en, 1'b0);
        check("win_err_kept", timeout_err, 5'b01000);
        ack = 1'b1; start = 1'b1; cyc(); ack = 1'b0; start = 1'b0;
        check("ack_start_state", state, 2'b00);
        start = 1'b1; cyc(); start = 1'b0;
        check("replay_state", state, 2'b01);
        check("replay_err_cleared", timeout_err, 5'b0);

        // win_in and lose_in together while waiting: lose wins, burst aborted.
        done_mask = 5'b0;
        repeat (4) frame_pulse();
        repeat (3) cyc();
        check("wait_busy", busy, 1'b1);
        win_in = 1'b1; lose_in = 1'b1; cyc(); win_in = 1'b0; lose_in = 1'b0;
        check("lose_state", state, 2'b11);
        check("lose_step", actor_if.step, 5'b0);
        check("lose_busy", busy, 1'b0);
        n = step_log.size();
        repeat (70) cyc();
        check("lose_no_steps", step_log.size() - n, 0);
        ack = 1'b1; cyc(); ack = 1'b0;
        check("lose_ack_state", state, 2'b00);

        // speed_sel=0, done withheld: ticks pile up, overrun saturates.
        speed_sel = 2'd0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int f = 1; f <= 400; f++) begin
            frame_pulse();
            if (f == 100) check("overrun_100", overrun_cnt, 8'd99);
        end
        check("overrun_sat", overrun_cnt, 8'd255);

        // Reset in the middle of a wait: outputs clear without a clock edge.
        check("pre_reset_busy", busy, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_outputs", {state, play_en, clear, busy, timeout_err, overrun_cnt, actor_if.step}, 32'd0);
        cyc(); cyc();
        Reset = 1'b0;
        clear_log();
        repeat (3) frame_pulse();
        repeat (5) cyc();
        check("post_reset_no_steps", step_log.size(), 0);
        check("post_reset_state", state, 2'b00);
        start = 1'b1; cyc(); start = 1'b0;
        frame_pulse();
        repeat (2) cyc();
        check("fresh_first_step", (step_log.size() > 0) ? step_log[0] : 99, 0);

        check("step_onehot", multi_hot, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
